// File: rtl/sevenseg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state encoding and the hex-to-segment table.
package sevenseg_scan_ctrl_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam logic [6:0]  SEG_BLANK = 7'h00;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3f;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5b;
            4'h3:    s = 7'h4f;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6d;
            4'h6:    s = 7'h7d;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7f;
            4'h9:    s = 7'h67;
            4'ha:    s = 7'h77;
            4'hb:    s = 7'h7c;
            4'hc:    s = 7'h39;
            4'hd:    s = 7'h5e;
            4'he:    s = 7'h79;
            4'hf:    s = 7'h71;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake and display-drive bundle of the seven-segment scan controller.
interface sevenseg_scan_ctrl_if
    import sevenseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = 4
);
    logic                 load;
    logic                 ready;
    logic [4*NDIG-1:0]    data;
    logic [NDIG-1:0]      dp_in;
    logic                 lz_blank;
    logic [SEG_W-1:0]     seg;
    logic                 dp;
    logic [NDIG-1:0]      dig_en;
    logic                 frame_start;

    modport master (
        output load, data, dp_in, lz_blank,
        input  ready, seg, dp, dig_en, frame_start
    );

    modport slave (
        input  load, data, dp_in, lz_blank,
        output ready, seg, dp, dig_en, frame_start
    );
endinterface

// File: rtl/digits_sevenseg.sv
// Combinational hex nibble to seven-segment decoder.
module digits_sevenseg
    import sevenseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(nib);
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: BLANK/SHOW scan per digit,
// double-buffered display value swapped only at frame boundaries.
module sevenseg_scan_ctrl
    import sevenseg_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG      = 4,
    parameter logic [15:0] DWELL     = 16'd5000,
    parameter logic [7:0]  BLANK_CYC = 8'd50
) (
    input logic                 clk,
    input logic                 rst_n,
    sevenseg_scan_ctrl_if.slave bus
);
    localparam int unsigned MAXC       = (int'(DWELL) > int'(BLANK_CYC)) ? int'(DWELL) : int'(BLANK_CYC);
    localparam int unsigned CW         = $clog2(MAXC + 1);
    localparam int unsigned IW         = $clog2(NDIG);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(DWELL - 16'd1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 8'd1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    state_t              state_r, state_s;
    logic [IW-1:0]       idx_r, idx_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic                run_r;
    logic                enter_frame_s;

    logic [4*NDIG-1:0]   pend_r, active_r;
    logic [NDIG-1:0]     pend_dp_r, active_dp_r;
    logic                pend_valid_r;

    logic [3:0]          nib_s;
    logic                sel_dp_s;
    logic                hide_s;
    logic                zacc_s;
    logic [NDIG-1:0]     zero_from_s;
    logic [6:0]          dec_seg_s;

    logic [6:0]          seg_r, seg_s;
    logic                dp_r, dp_s;
    logic [NDIG-1:0]     dig_en_r, dig_en_s;
    logic                frame_start_r;

    // Scan sequencing; run_r low means the first edge after reset opens frame 0.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        cnt_s         = cnt_r;
        enter_frame_s = 1'b0;
        if (!run_r) begin
            state_s       = BLANK;
            idx_s         = {IW{1'b0}};
            cnt_s         = {CW{1'b0}};
            enter_frame_s = 1'b1;
        end else begin
            case (state_r)
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = SHOW;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                SHOW: begin
                    if (cnt_r == SHOW_LAST) begin
                        state_s = BLANK;
                        cnt_s   = {CW{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            idx_s         = {IW{1'b0}};
                            enter_frame_s = 1'b1;
                        end else begin
                            idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = BLANK;
                    idx_s   = {IW{1'b0}};
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Select the nibble/dp of the digit about to be lit and evaluate leading-zero blanking.
    always_comb begin
        nib_s       = 4'h0;
        sel_dp_s    = 1'b0;
        hide_s      = 1'b0;
        zacc_s      = 1'b1;
        zero_from_s = {NDIG{1'b0}};
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            zacc_s         = zacc_s & (active_r[4*i +: 4] == 4'h0);
            zero_from_s[i] = zacc_s;
        end
        for (int i = 0; i < int'(NDIG); i++) begin
            nib_s    = (idx_s == IW'(i)) ? active_r[4*i +: 4] : nib_s;
            sel_dp_s = (idx_s == IW'(i)) ? active_dp_r[i] : sel_dp_s;
            hide_s   = (idx_s == IW'(i)) ? (bus.lz_blank && (i != 0) && zero_from_s[i]) : hide_s;
        end
    end

    digits_sevenseg u_dec (
        .nib (nib_s),
        .seg (dec_seg_s)
    );

    // Next values of the display drive; all dark outside SHOW.
    always_comb begin
        dig_en_s = {NDIG{1'b0}};
        seg_s    = SEG_BLANK;
        dp_s     = 1'b0;
        if (state_s == SHOW) begin
            dig_en_s = {{(NDIG-1){1'b0}}, 1'b1} << idx_s;
            seg_s    = hide_s ? SEG_BLANK : dec_seg_s;
            dp_s     = sel_dp_s;
        end else begin
            dig_en_s = {NDIG{1'b0}};
            seg_s    = SEG_BLANK;
            dp_s     = 1'b0;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= BLANK;
            idx_r   <= {IW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            run_r   <= 1'b1;
        end
    end

    // Pending/active buffers: swap only when a frame opens so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r       <= {(4*NDIG){1'b0}};
            pend_dp_r    <= {NDIG{1'b0}};
            pend_valid_r <= 1'b0;
            active_r     <= {(4*NDIG){1'b0}};
            active_dp_r  <= {NDIG{1'b0}};
        end else if (enter_frame_s && pend_valid_r) begin
            active_r     <= pend_r;
            active_dp_r  <= pend_dp_r;
            pend_valid_r <= 1'b0;
        end else if (bus.load && !pend_valid_r) begin
            pend_r       <= bus.data;
            pend_dp_r    <= bus.dp_in;
            pend_valid_r <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // Output registers, all updated on the same edge as the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r         <= SEG_BLANK;
            dp_r          <= 1'b0;
            dig_en_r      <= {NDIG{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_s;
            dp_r          <= dp_s;
            dig_en_r      <= dig_en_s;
            frame_start_r <= enter_frame_s;
        end
    end

    assign bus.ready       = ~pend_valid_r;
    assign bus.seg         = seg_r;
    assign bus.dp          = dp_r;
    assign bus.dig_en      = dig_en_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NDIG=4, DWELL=4, BLANK_CYC=1 (20-cycle frame).
module tb_sevenseg_scan_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [3:0] cap_dig [21];
    logic [6:0] cap_seg [21];
    logic       cap_dp  [21];
    logic       cap_fs  [21];

    sevenseg_scan_ctrl_if #(.NDIG(4)) bus ();

    sevenseg_scan_ctrl #(
        .NDIG      (4),
        .DWELL     (16'd4),
        .BLANK_CYC (8'd1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench stopped by watchdog");
    end

    // Expected frame pattern: sample k within a frame; k%5==0 is dead time.
    function automatic logic [3:0] e_dig(input int k);
        logic [3:0] r;
        r = 4'b0000;
        if ((k % 5) != 0) r[(k % 20) / 5] = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] e_seg(input int k, input logic [27:0] segs);
        if ((k % 5) != 0) return segs[7*((k % 20) / 5) +: 7];
        else return 7'h00;
    endfunction

    function automatic logic e_dp(input int k, input logic [3:0] dps);
        if ((k % 5) != 0) return dps[(k % 20) / 5];
        else return 1'b0;
    endfunction

    function automatic logic e_fs(input int k);
        return ((k % 20) == 0);
    endfunction

    // Record 21 samples starting at the next (or current) frame_start.
    task automatic capture(output bit found);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (found) begin
            for (int k = 0; k < 21; k++) begin
                cap_dig[k] = bus.dig_en;
                cap_seg[k] = bus.seg;
                cap_dp[k]  = bus.dp;
                cap_fs[k]  = bus.frame_start;
                if (k < 20) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.data     = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.seg !== 7'h00 || bus.dp !== 1'b0 || bus.dig_en !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs seg=%h dp=%b dig_en=%b, want 00 0 0000", bus.seg, bus.dp, bus.dig_en);
        end
        tests++;
        if (bus.frame_start !== 1'b0 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ctrl frame_start=%b ready=%b, want 0 1", bus.frame_start, bus.ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.frame_start !== 1'b1 || bus.dig_en !== 4'b0000) begin
            fails++;
            $display("FAIL first_frame_start frame_start=%b dig_en=%b, want 1 0000", bus.frame_start, bus.dig_en);
        end
    endtask

    task automatic test_scan;
        bit found;
        logic [27:0] segs;
        logic [3:0]  dps;
        segs = {7'h3f, 7'h3f, 7'h3f, 7'h3f};
        dps  = 4'b0000;
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps) || cap_fs[k] !== e_fs(k)) begin
                fails++;
                $display("FAIL scan k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps), cap_fs[k], e_fs(k));
            end
        end
    endtask

    task automatic test_load;
        bit found;
        bit bad;
        logic [27:0] segs;
        logic [3:0]  dps;
        segs = {7'h06, 7'h5b, 7'h77, 7'h71};
        dps  = 4'b0000;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready_before ready=%b, want 1", bus.ready);
        end
        bus.load  = 1'b1;
        bus.data  = 16'h12AF;
        bus.dp_in = 4'b0000;
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b0 || bus.seg !== 7'h3f || bus.dig_en !== 4'b0001) begin
            fails++;
            $display("FAIL load_accept ready=%b seg=%h dig_en=%b, want 0 3f 0001", bus.ready, bus.seg, bus.dig_en);
        end
        bus.data  = 16'h5555;
        bus.dp_in = 4'b1111;
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b0) begin
            fails++;
            $display("FAIL load_ignored_ready ready=%b, want 0", bus.ready);
        end
        bus.load = 1'b0;
        found = 1'b0;
        bad   = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (bus.seg !== 7'h00 && bus.seg !== 7'h3f) bad = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (!found || bad) begin
            fails++;
            $display("FAIL load_no_tearing found=%b bad=%b, want 1 0", found, bad);
        end
        tests++;
        if (bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL load_ready_after ready=%b, want 1", bus.ready);
        end
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps) || cap_fs[k] !== e_fs(k)) begin
                fails++;
                $display("FAIL load_frame k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps), cap_fs[k], e_fs(k));
            end
        end
    endtask

    task automatic test_lz_blank;
        bit found;
        logic [27:0] segs;
        logic [3:0]  dps;
        dps = 4'b0000;
        bus.lz_blank = 1'b1;
        bus.load     = 1'b1;
        bus.data     = 16'h0050;
        bus.dp_in    = 4'b0000;
        @(negedge clk);
        bus.load = 1'b0;
        segs = {7'h00, 7'h00, 7'h6d, 7'h3f};
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps)) begin
                fails++;
                $display("FAIL lz_on k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps));
            end
        end
        bus.lz_blank = 1'b0;
        segs = {7'h3f, 7'h3f, 7'h6d, 7'h3f};
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps)) begin
                fails++;
                $display("FAIL lz_off k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps));
            end
        end
    endtask

    task automatic test_dp;
        bit found;
        logic [27:0] segs;
        logic [3:0]  dps;
        segs = {7'h3f, 7'h3f, 7'h3f, 7'h3f};
        dps  = 4'b0100;
        bus.load  = 1'b1;
        bus.data  = 16'h0000;
        bus.dp_in = 4'b0100;
        @(negedge clk);
        bus.load = 1'b0;
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps)) begin
                fails++;
                $display("FAIL dp k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit found;
        logic [27:0] segs;
        logic [3:0]  dps;
        segs = {7'h07, 7'h07, 7'h07, 7'h07};
        dps  = 4'b0000;
        bus.load  = 1'b1;
        bus.data  = 16'h3333;
        bus.dp_in = 4'b0000;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (18) @(negedge clk);
        tests++;
        if (bus.ready !== 1'b0 || bus.dig_en !== 4'b1000) begin
            fails++;
            $display("FAIL b2b_pending ready=%b dig_en=%b, want 0 1000", bus.ready, bus.dig_en);
        end
        bus.load = 1'b1;
        bus.data = 16'h7777;
        @(negedge clk);
        tests++;
        if (bus.frame_start !== 1'b1 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_transfer frame_start=%b ready=%b, want 1 1", bus.frame_start, bus.ready);
        end
        @(negedge clk);
        tests++;
        if (bus.ready !== 1'b0 || bus.seg !== 7'h4f) begin
            fails++;
            $display("FAIL b2b_next_accept ready=%b seg=%h, want 0 4f", bus.ready, bus.seg);
        end
        bus.load = 1'b0;
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps)) begin
                fails++;
                $display("FAIL b2b_frame k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps));
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        logic [27:0] segs;
        logic [3:0]  dps;
        segs = {7'h3f, 7'h3f, 7'h3f, 7'h3f};
        dps  = 4'b0000;
        bus.load  = 1'b1;
        bus.data  = 16'h1111;
        bus.dp_in = 4'b1111;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (11) @(negedge clk);
        tests++;
        if (bus.dig_en !== 4'b0100 || bus.ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_pre dig_en=%b ready=%b, want 0100 0", bus.dig_en, bus.ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.seg !== 7'h00 || bus.dp !== 1'b0 || bus.dig_en !== 4'b0000 || bus.frame_start !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async seg=%h dp=%b dig_en=%b fs=%b, want 00 0 0000 0", bus.seg, bus.dp, bus.dig_en, bus.frame_start);
        end
        tests++;
        if (bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pend ready=%b, want 1", bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.frame_start !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_restart frame_start=%b, want 1", bus.frame_start);
        end
        capture(found);
        for (int k = 0; k < 21; k++) begin
            tests++;
            if (!found || cap_dig[k] !== e_dig(k) || cap_seg[k] !== e_seg(k, segs) || cap_dp[k] !== e_dp(k, dps) || cap_fs[k] !== e_fs(k)) begin
                fails++;
                $display("FAIL rst_mid_frame k=%0d found=%b dig=%b/%b seg=%h/%h dp=%b/%b fs=%b/%b (got/want)",
                         k, found, cap_dig[k], e_dig(k), cap_seg[k], e_seg(k, segs), cap_dp[k], e_dp(k, dps), cap_fs[k], e_fs(k));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_scan();
        test_load();
        test_lz_blank();
        test_dp();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DWELL, default 16'd5000, clock cycles one digit is lit (>=1).
REQ-003 SHALL have parameter BLANK_CYC, default 8'd50, dead-time cycles with all digits off before each digit (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port load  input  1  offer new display value.
REQ-007 SHALL have port ready  output  1  load accepted this cycle when load&&ready.
REQ-008 SHALL have port data  input  4*NDIG  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
REQ-009 SHALL have port dp_in  input  NDIG  decimal point per digit, captured with data.
REQ-010 SHALL have port lz_blank  input  1  enable leading-zero blanking, sampled live.
REQ-011 SHALL have port seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp  output  1  active-high decimal point.
REQ-013 SHALL have port dig_en  output  NDIG  one-hot active-high digit enable, all-zero when blanked.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse when digit 0 dead time begins.

Function
REQ-015 SHALL implement FSM states BLANK and SHOW with a digit index idx (0..NDIG-1) and a cycle counter.
REQ-016 In BLANK, dig_en, seg and dp SHALL be zero for exactly BLANK_CYC cycles, then go to SHOW with the same idx.
REQ-017 In SHOW, dig_en SHALL equal 1<<idx for exactly DWELL cycles, then go to BLANK with idx+1, wrapping NDIG-1 -> 0.
REQ-018 Frame length SHALL be NDIG*(BLANK_CYC+DWELL) cycles, exactly periodic.
REQ-019 seg SHALL be the hex decode of active nibble idx (0..F: 3f,06,5b,4f,66,6d,7d,07,7f,67,77,7c,39,5e,79,71); seg, dp, dig_en SHALL all be registered and change on the same edge.
REQ-020 Data path SHALL be double-buffered: pending register (pend, pend_valid) and active register; ready SHALL equal !pend_valid.
REQ-021 On load&&ready, data/dp_in SHALL be captured into pend and pend_valid set next cycle; load while !ready SHALL be ignored.
REQ-022 On the cycle BLANK is entered with idx=0, if pend_valid, active SHALL take pend and pend_valid SHALL clear; frame_start SHALL pulse that cycle; no mid-frame tearing.
REQ-023 With lz_blank=1, digit i>0 SHALL show seg=0 when it and all higher nibbles are zero; digit 0 never blanked; dp unaffected.
REQ-024 load asserted on the transfer cycle SHALL not be accepted (ready=0 that cycle); it is accepted the next cycle.

Reset
REQ-025 While rst_n=0: state=BLANK, idx=0, counter=0, active and pend zero, pend_valid=0, ready=1, seg=0, dp=0, dig_en=0, frame_start=0.
REQ-026 After rst_n rises, first frame_start SHALL pulse on the first clk edge, then a full BLANK_CYC dead time follows.
REQ-027 Reset asserted mid-frame SHALL immediately force all outputs to reset values and discard pend.

Structure
REQ-028 Shared package SHALL hold the segment constants (SEG_BLANK=7'h00) and the state encoding typedef (BLANK, SHOW).
REQ-029 Decode SHALL be one instance of digits_sevenseg fed by the muxed nibble; counter widths derived by clog2 of DWELL/BLANK_CYC.

Verification (NDIG=4, DWELL=4, BLANK_CYC=1)
REQ-030 Reset release, no load -> dig_en sequence 0000,0001x4,0000,0010x4,... seg=3f when lit; frame_start every 20 cycles.
REQ-031 Load data=16'h12AF mid-frame -> ready low next cycle; display unchanged until next frame_start; then digits 0..3 show 71,77,5b,06; ready returns high.
REQ-032 Second load while ready=0 -> ignored; display keeps first value.
REQ-033 data=16'h0050, lz_blank=1 -> digit3 seg=00, digit2 seg=00, digit1 6d, digit0 3f; toggle lz_blank=0 -> digits3,2 show 3f.
REQ-034 dp_in=4'b0100 -> dp=1 only while dig_en=0100; dp=0 during BLANK.
REQ-035 rst_n pulsed low during SHOW of digit 2 -> outputs zero same cycle, pend cleared, scan restarts at digit 0.
